alu_control_muldiv: RTL and testbench

Next-generation ALU control for the single-cycle RV32 core.
- Decodes ALUOp/funct3/funct7/opCode into a 4-bit ALUControl covering full RV32I (XOR, SRA, SLTU distinct).
- Adds a sequenced RV32M multiply/divide engine with a stall handshake.
- Sits between the main control unit and the ALU/writeback mux. It stalls the PC while an M-extension op iterates.

---
 rtl/alu_control_muldiv_if.sv | 29 ++
 rtl/alu_control_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_alu_control_muldiv.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_muldiv_if.sv
// Decode/operand bus between the main control unit and the ALU control block
// with its RV32M multiply/divide result and stall handshake.
interface alu_control_muldiv_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
);
  logic              valid_i;
  logic [2:0]        ALUOp;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [6:0]        opCode;
  logic [XLEN-1:0]   rs1_i;
  logic [XLEN-1:0]   rs2_i;
  logic [CTRL_W-1:0] ALUControl;
  logic              stall_o;
  logic              md_sel_o;
  logic              md_done_o;
  logic [XLEN-1:0]   md_result_o;

  modport master (
    output valid_i, ALUOp, funct3, funct7, opCode, rs1_i, rs2_i,
    input  ALUControl, stall_o, md_sel_o, md_done_o, md_result_o
  );

  modport slave (
    input  valid_i, ALUOp, funct3, funct7, opCode, rs1_i, rs2_i,
    output ALUControl, stall_o, md_sel_o, md_done_o, md_result_o
  );
endinterface

// File: rtl/alu_control_muldiv.sv
// RV32I ALU control decode plus a sequenced RV32M multiply/divide engine that stalls the PC.
// Define ALU_FAST_MUL_EN to compute MUL* combinationally in the accept cycle.
module alu_control_muldiv #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_control_muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

`ifdef ALU_FAST_MUL_EN
  localparam logic [1:0] S_MUL_ENTRY = S_DONE;
`else
  localparam logic [1:0] S_MUL_ENTRY = S_MUL;
`endif

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [CTRL_W-1:0] C_AND    = 4'b0000;
  localparam logic [CTRL_W-1:0] C_OR     = 4'b0001;
  localparam logic [CTRL_W-1:0] C_ADD    = 4'b0010;
  localparam logic [CTRL_W-1:0] C_SRL    = 4'b0011;
  localparam logic [CTRL_W-1:0] C_SLT    = 4'b0100;
  localparam logic [CTRL_W-1:0] C_MDPASS = 4'b0101;
  localparam logic [CTRL_W-1:0] C_SUB    = 4'b0110;
  localparam logic [CTRL_W-1:0] C_SLL    = 4'b0111;
  localparam logic [CTRL_W-1:0] C_XOR    = 4'b1000;
  localparam logic [CTRL_W-1:0] C_SRA    = 4'b1001;
  localparam logic [CTRL_W-1:0] C_SLTU   = 4'b1010;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] prod,
                                              input logic neg, input logic lo);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return lo ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_fix(input logic [2*XLEN-1:0] qr,
                                              input logic neg, input logic is_rem);
    return cond_neg(is_rem ? qr[2*XLEN-1:XLEN] : qr[XLEN-1:0], neg);
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [CTRL_W-1:0] alu_ctl;
  logic              is_rtype, is_mop, start, last_iter;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic              a_signed, b_signed, neg_a, neg_b, neg_res;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic              div_zero, div_ovf;

  // Accept-cycle latched operands; acc holds {product} or {remainder, quotient}
  logic [2*XLEN-1:0] acc_p1;
  logic [XLEN-1:0]   opd_p1;
  logic [2:0]        op_p1;
  logic              neg_p1;
  logic [XLEN-1:0]   res_p1;

  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign is_rtype = (bus.opCode == OPC_OP);
  assign is_mop   = is_rtype && (bus.funct7 == 7'b0000001) && (bus.ALUOp == 3'b010);

  always_comb begin
    alu_ctl = C_ADD;
    case (bus.ALUOp)
      3'b000: alu_ctl = C_ADD;
      3'b001: alu_ctl = C_SUB;
      3'b011: alu_ctl = C_SRL;
      3'b010: begin
        if (is_mop) begin
          alu_ctl = C_MDPASS;
        end else begin
          case (bus.funct3)
            3'b000:  alu_ctl = (is_rtype && bus.funct7[5]) ? C_SUB : C_ADD;
            3'b001:  alu_ctl = C_SLL;
            3'b010:  alu_ctl = C_SLT;
            3'b011:  alu_ctl = C_SLTU;
            3'b100:  alu_ctl = C_XOR;
            3'b101:  alu_ctl = bus.funct7[5] ? C_SRA : C_SRL;
            3'b110:  alu_ctl = C_OR;
            default: alu_ctl = C_AND;
          endcase
        end
      end
      default: alu_ctl = C_ADD;
    endcase
  end

  assign bus.ALUControl = alu_ctl;

  // MUL (000) is sign-agnostic in its low half, so it runs fully unsigned.
  assign a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1] ^ bus.funct3[0]);
  assign b_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);

  assign rs1_s   = bus.rs1_i;
  assign rs2_s   = bus.rs2_i;
  assign neg_a   = a_signed && (rs1_s < 0);
  assign neg_b   = b_signed && (rs2_s < 0);
  assign mag_a   = cond_neg(bus.rs1_i, neg_a);
  assign mag_b   = cond_neg(bus.rs2_i, neg_b);
  assign neg_res = (bus.funct3[2] && bus.funct3[1]) ? neg_a : (neg_a ^ neg_b);

  assign div_zero = (bus.rs2_i == '0);
  assign div_ovf  = ~bus.funct3[0] && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2_i);
  assign special_res = bus.funct3[1] ? (div_zero ? bus.rs1_i : '0)
                                     : (div_zero ? '1 : bus.rs1_i);

  assign start     = rst && (state == S_IDLE) && bus.valid_i && is_mop;
  assign last_iter = (cnt == CNT_W'(XLEN-1));

  // Iteration stage: one shift-add or one restoring-subtract step per cycle
  assign mul_sum  = {1'b0, acc_p1[2*XLEN-1:XLEN]} + {1'b0, (acc_p1[0] ? opd_p1 : '0)};
  assign mul_next = {mul_sum, acc_p1[XLEN-1:1]};

  assign div_trial = {acc_p1[2*XLEN-1:XLEN], acc_p1[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, opd_p1};
  assign div_next  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_p1[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_p1[XLEN-2:0], 1'b1};

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            if (bus.funct3[2]) state <= (div_zero || div_ovf) ? S_DONE : S_DIV;
            else               state <= S_MUL_ENTRY;
          end
        end
        S_MUL, S_DIV: begin
          if (last_iter) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op_p1  <= bus.funct3;
      neg_p1 <= neg_res;
      opd_p1 <= bus.funct3[2] ? mag_b : mag_a;
      acc_p1 <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
      if (bus.funct3[2]) res_p1 <= special_res;
`ifdef ALU_FAST_MUL_EN
      else               res_p1 <= mul_fix(fast_prod, neg_res, bus.funct3[1:0] == 2'b00);
`endif
    end else if (state == S_MUL) begin
      acc_p1 <= mul_next;
      if (last_iter) res_p1 <= mul_fix(mul_next, neg_p1, op_p1[1:0] == 2'b00);
    end else if (state == S_DIV) begin
      acc_p1 <= div_next;
      if (last_iter) res_p1 <= div_fix(div_next, neg_p1, op_p1[1]);
    end
  end

  // Result stage: everything is gated by DONE so an aborted op never leaks out
  assign bus.stall_o     = start || (state == S_MUL) || (state == S_DIV);
  assign bus.md_done_o   = (state == S_DONE);
  assign bus.md_sel_o    = (state == S_DONE);
  assign bus.md_result_o = (state == S_DONE) ? res_p1 : '0;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Scoreboard bench for alu_control_muldiv: decode sweep, RV32M results, latency,
// divide special cases, held M-op in DONE and asynchronous abort.
module tb_alu_control_muldiv;

  localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  alu_control_muldiv_if #(.XLEN(XLEN), .CTRL_W(4)) bus ();

  alu_control_muldiv #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub;               return p[31:0];  end
      3'd1: begin p = sa * sb;               return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);     return p[63:32]; end
      3'd3: begin p = ua * ub;               return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic dec(input string tag, input logic [2:0] aop, f3,
                     input logic [6:0] f7, opc, input logic [3:0] exp);
    bus.ALUOp  = aop;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.opCode = opc;
    #1;
    check(tag, bus.ALUControl, exp);
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, b);
    bus.valid_i = 1'b1;
    bus.ALUOp   = 3'b010;
    bus.opCode  = 7'b0110011;
    bus.funct7  = 7'b0000001;
    bus.funct3  = f3;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
  endtask

  // Presents an M-op, holds it through DONE, then drops valid.
  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a, b,
                         input logic [31:0] exp, input int lat);
    exp_t e;
    int   edges, stalls;
    e.tag = tag;
    e.val = exp;
    sb_q.push_back(e);
    drive_mop(f3, a, b);
    #1;
    check({tag, "_acc_stall"}, bus.stall_o, 1);
    check({tag, "_mdpass"}, bus.ALUControl, 4'b0101);
    edges  = 0;
    stalls = 1;
    do begin
      @(posedge clk); #1;
      edges++;
      bus.rs1_i = $urandom;
      bus.rs2_i = $urandom;
      if (!bus.md_done_o && bus.stall_o) stalls++;
    end while (!bus.md_done_o && edges < 200);
    check({tag, "_latency"}, edges, lat);
    check({tag, "_stalls"}, stalls, lat);
    check({tag, "_done_stall"}, bus.stall_o, 0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    #1;
    check({tag, "_one_pulse"}, bus.md_done_o, 0);
    check({tag, "_no_restart"}, bus.stall_o, 0);
  endtask

  always @(negedge clk) begin
    if (bus.md_done_o) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.tag, bus.md_result_o, e.val);
        check({e.tag, "_sel"}, bus.md_sel_o, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        special;

    rst         = 1'b0;
    bus.valid_i = 1'b0;
    bus.ALUOp   = 3'b000;
    bus.funct3  = 3'b000;
    bus.funct7  = 7'b0;
    bus.opCode  = 7'b0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", bus.stall_o, 0);
    check("rst_sel", bus.md_sel_o, 0);
    check("rst_done", bus.md_done_o, 0);
    check("rst_result", bus.md_result_o, 0);
    @(negedge clk) rst = 1'b1;

    dec("dec_r_sub",   3'b010, 3'b000, 7'b0100000, 7'b0110011, 4'b0110);
    dec("dec_i_add",   3'b010, 3'b000, 7'b0100000, 7'b0010011, 4'b0010);
    dec("dec_sra",     3'b010, 3'b101, 7'b0100000, 7'b0010011, 4'b1001);
    dec("dec_srl",     3'b010, 3'b101, 7'b0000000, 7'b0110011, 4'b0011);
    dec("dec_aop111",  3'b111, 3'b000, 7'b0100000, 7'b0110011, 4'b0010);
    dec("dec_aop000",  3'b000, 3'b101, 7'b0000000, 7'b0000011, 4'b0010);
    dec("dec_aop001",  3'b001, 3'b000, 7'b0000000, 7'b1100011, 4'b0110);
    dec("dec_aop011",  3'b011, 3'b000, 7'b0000000, 7'b0110011, 4'b0011);
    dec("dec_sll",     3'b010, 3'b001, 7'b0000000, 7'b0110011, 4'b0111);
    dec("dec_slt",     3'b010, 3'b010, 7'b0000000, 7'b0110011, 4'b0100);
    dec("dec_sltu",    3'b010, 3'b011, 7'b0000000, 7'b0110011, 4'b1010);
    dec("dec_xor",     3'b010, 3'b100, 7'b0000000, 7'b0110011, 4'b1000);
    dec("dec_or",      3'b010, 3'b110, 7'b0000000, 7'b0110011, 4'b0001);
    dec("dec_and",     3'b010, 3'b111, 7'b0000000, 7'b0110011, 4'b0000);
    dec("dec_mop_nv",  3'b010, 3'b000, 7'b0000001, 7'b0110011, 4'b0101);
    check("nv_no_stall", bus.stall_o, 0);
    @(posedge clk); #1;
    check("nv_no_start", bus.stall_o, 0);

    run_mop("mul_1234x10",  3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, MUL_LAT);
    run_mop("mulh_m1m1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_mop("mulhu_m1m1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_mop("mulhsu_m1m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_mop("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
    run_mop("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
    run_mop("divu_7_0",     3'd5, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_mop("remu_7_0",     3'd7, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1);
    run_mop("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_mop("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    drive_mop(3'd4, 32'd1000, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_stall", bus.stall_o, 0);
    check("abort_done", bus.md_done_o, 0);
    check("abort_sel", bus.md_sel_o, 0);
    check("abort_result", bus.md_result_o, 0);
    @(posedge clk); #1;
    check("abort_held_idle", bus.stall_o, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_released_idle", bus.stall_o, 0);
    run_mop("mul_3x5", 3'd0, 32'd3, 32'd5, 32'd15, MUL_LAT);

    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i == 3) ? 32'h0 : $urandom;
      if (i == 5) b = 32'($urandom_range(1, 9));
      special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      run_mop($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ref_md(f3, a, b),
              special ? 1 : (f3[2] ? DIV_LAT : MUL_LAT));
    end

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
